// File: rtl/cache_arb_pkg.sv
// Shared definitions for the I/D cache memory arbiter: state encoding and
// default sizing.
package cache_arb_pkg;

    localparam int ADDR_W_DEFAULT     = 16;
    localparam int DATA_W_DEFAULT     = 16;
    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_ISSUE = 3'd1,
        I_WAIT  = 3'd2,
        D_ISSUE = 3'd3,
        D_WAIT  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive D grants taken while the I port was also
// waiting; at_max tells the arbiter to let I through next.
module arb_starve_cnt
    import cache_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int CNT_W      = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment, increment stops at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_VAL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX_VAL);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates a single shared memory port between an I-cache fill port and a
// D-cache fill/writeback port. D normally wins ties; I is forced through after
// STARVE_MAX consecutive D wins while it was pending.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-cache fill port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    // data-cache fill/writeback port
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    // shared memory port
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy,
    output logic              grant_d
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arb_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              at_max;
    logic [CNT_W-1:0]  starve_cnt;
    logic              pick_d;
    logic              pick_i;
    logic              cnt_inc;
    logic              cnt_clr;
    logic              issuing;

    // Grant decision, only meaningful while idle; also steers the starvation counter.
    always_comb begin
        pick_d  = (state_q == IDLE) && d_req && !(i_req && at_max);
        pick_i  = (state_q == IDLE) && i_req && !pick_d;
        cnt_inc = pick_d && i_req;
        cnt_clr = pick_i || (pick_d && !i_req);
    end

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .cnt    (starve_cnt),
        .at_max (at_max)
    );

    // The raw count is only useful for observation; arbitration uses at_max.
    logic unused_starve_cnt;
    assign unused_starve_cnt = ^starve_cnt;

    // Transaction FSM: capture the winner once, issue until accepted, wait for completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q <= D_ISSUE;
                        addr_q  <= d_addr;
                        wr_q    <= d_wr;
                        wdata_q <= d_wdata;
                    end else if (pick_i) begin
                        state_q <= I_ISSUE;
                        addr_q  <= i_addr;
                        wr_q    <= 1'b0;
                        wdata_q <= '0;
                    end
                end
                I_ISSUE: if (!mem_stall) state_q <= I_WAIT;
                D_ISSUE: if (!mem_stall) state_q <= D_WAIT;
                I_WAIT:  if (mem_done)   state_q <= IDLE;
                D_WAIT:  if (mem_done)   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode: memory side from captured registers, done/rdata gated by ownership.
    always_comb begin
        issuing   = (state_q == I_ISSUE) || (state_q == D_ISSUE);
        mem_req   = issuing;
        mem_wr    = issuing && wr_q;
        mem_addr  = issuing ? addr_q : '0;
        mem_wdata = issuing ? wdata_q : '0;
        i_done    = (state_q == I_WAIT) && mem_done;
        d_done    = (state_q == D_WAIT) && mem_done;
        i_rdata   = i_done ? mem_rdata : '0;
        d_rdata   = d_done ? mem_rdata : '0;
        busy      = (state_q != IDLE);
        grant_d   = (state_q == D_ISSUE) || (state_q == D_WAIT);
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios with literal expectations
// plus a long randomized run, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_cache_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_stall;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          grant_d;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_stall (mem_stall),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant_d   (grant_d)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // values to drive in the next cycle
    logic          n_rst, n_i_req, n_d_req, n_d_wr, n_mem_stall, n_mem_done;
    logic [AW-1:0] n_i_addr, n_d_addr;
    logic [DW-1:0] n_d_wdata, n_mem_rdata;
    bit            rand_mem = 1'b0;

    // Transaction-level model: who owns memory (0 none, 1 I, 2 D), whether
    // memory has accepted the request, the captured request, and how many D
    // wins in a row happened while I was also asking.
    int            m_own   = 0;
    bit            m_acc   = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    bit            m_wr    = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    int            m_d_streak = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model over the clock edge that just sampled the held inputs.
    task automatic model_step();
        if (rst) begin
            m_own = 0; m_acc = 1'b0; m_addr = '0; m_wr = 1'b0; m_wdata = '0;
            m_d_streak = 0;
        end else if (m_own == 0) begin
            if (d_req && !(i_req && m_d_streak == SMAX)) begin
                m_own = 2; m_acc = 1'b0;
                m_addr = d_addr; m_wr = d_wr; m_wdata = d_wdata;
                m_d_streak = i_req ? ((m_d_streak < SMAX) ? m_d_streak + 1 : SMAX) : 0;
            end else if (i_req) begin
                m_own = 1; m_acc = 1'b0;
                m_addr = i_addr; m_wr = 1'b0; m_wdata = '0;
                m_d_streak = 0;
            end
        end else if (!m_acc) begin
            if (!mem_stall) m_acc = 1'b1;
        end else if (mem_done) begin
            m_own = 0; m_acc = 1'b0;
        end
    endtask

    // Compare every DUT output against what the model says this cycle must show.
    task automatic check_model();
        bit e_issue, e_idone, e_ddone;
        e_issue = (m_own != 0) && !m_acc;
        e_idone = (m_own == 1) && m_acc && mem_done;
        e_ddone = (m_own == 2) && m_acc && mem_done;
        chk("busy",     32'(busy),    32'(m_own != 0));
        chk("grant_d",  32'(grant_d), 32'(m_own == 2));
        chk("mem_req",  32'(mem_req), 32'(e_issue));
        if (e_issue) begin
            chk("mem_addr",  32'(mem_addr),  32'(m_addr));
            chk("mem_wr",    32'(mem_wr),    32'(m_wr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        end
        chk("i_done",  32'(i_done),  32'(e_idone));
        chk("d_done",  32'(d_done),  32'(e_ddone));
        chk("i_rdata", 32'(i_rdata), e_idone ? 32'(mem_rdata) : 32'd0);
        chk("d_rdata", 32'(d_rdata), e_ddone ? 32'(mem_rdata) : 32'd0);
    endtask

    // One cycle: model crosses the edge, new inputs are driven, outputs are checked mid-cycle.
    task automatic tick();
        @(negedge clk);
        model_step();
        if (rand_mem) begin
            n_mem_done  = (m_own != 0 && m_acc) ? ($urandom % 2 == 0) : ($urandom % 8 == 0);
            n_mem_rdata = DW'($urandom);
        end
        rst = n_rst; i_req = n_i_req; i_addr = n_i_addr;
        d_req = n_d_req; d_wr = n_d_wr; d_addr = n_d_addr; d_wdata = n_d_wdata;
        mem_stall = n_mem_stall; mem_done = n_mem_done; mem_rdata = n_mem_rdata;
        #2;
        check_model();
    endtask

    task automatic zero_inputs();
        n_rst = 1'b0; n_i_req = 1'b0; n_i_addr = '0; n_d_req = 1'b0; n_d_wr = 1'b0;
        n_d_addr = '0; n_d_wdata = '0; n_mem_stall = 1'b0; n_mem_done = 1'b0; n_mem_rdata = '0;
    endtask

    task automatic do_reset();
        zero_inputs();
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        tick();
    endtask

    logic [AW-1:0] got[10];
    logic [AW-1:0] exp_order[10] = '{16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0100,
                                     16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0100};

    initial begin
        int ng;
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0;
        d_wdata = '0; mem_stall = 1'b0; mem_done = 1'b0; mem_rdata = '0;

        // reset: all outputs quiet in the cycle after reset
        do_reset();
        chk("rst_busy",      32'(busy),      0);
        chk("rst_grant_d",   32'(grant_d),   0);
        chk("rst_mem_req",   32'(mem_req),   0);
        chk("rst_mem_addr",  32'(mem_addr),  0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_mem_wr",    32'(mem_wr),    0);
        chk("rst_i_done",    32'(i_done),    0);
        chk("rst_d_done",    32'(d_done),    0);

        // D read alone, minimum latency
        n_d_req = 1'b1; n_d_addr = 16'h0040;
        tick();
        chk("rd_c0_mem_req", 32'(mem_req), 0);
        n_d_req = 1'b0; n_d_addr = '0;
        tick();
        chk("rd_c1_mem_req",  32'(mem_req),  1);
        chk("rd_c1_mem_addr", 32'(mem_addr), 32'h0040);
        chk("rd_c1_mem_wr",   32'(mem_wr),   0);
        n_mem_done = 1'b1; n_mem_rdata = 16'hBEEF;
        tick();
        chk("rd_c2_d_done",  32'(d_done),  1);
        chk("rd_c2_d_rdata", 32'(d_rdata), 32'hBEEF);
        chk("rd_c2_i_done",  32'(i_done),  0);
        n_mem_done = 1'b0;
        tick();
        chk("rd_c3_busy", 32'(busy), 0);

        // simultaneous requests held high; mem_done held high to show it is ignored outside WAIT
        do_reset();
        n_i_req = 1'b1; n_i_addr = 16'h0100; n_d_req = 1'b1; n_d_addr = 16'h0200;
        n_mem_done = 1'b1; n_mem_rdata = 16'h5A5A;
        ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            tick();
            if (mem_req) begin
                got[ng] = mem_addr;
                ng++;
            end
        end
        chk("grant_count", 32'(ng), 10);
        for (int k = 0; k < 10; k++) begin
            if (k < ng) chk("grant_order", 32'(got[k]), 32'(exp_order[k]));
        end

        // D write held off by three stall cycles; inputs scrambled after capture
        do_reset();
        n_d_req = 1'b1; n_d_wr = 1'b1; n_d_addr = 16'h0010; n_d_wdata = 16'h1234;
        tick();
        n_d_req = 1'b0; n_d_wr = 1'b0; n_d_addr = 16'hFFFF; n_d_wdata = 16'h0000;
        n_mem_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) n_mem_stall = 1'b0;
            tick();
            chk("stall_mem_req",   32'(mem_req),   1);
            chk("stall_mem_addr",  32'(mem_addr),  32'h0010);
            chk("stall_mem_wdata", 32'(mem_wdata), 32'h1234);
            chk("stall_mem_wr",    32'(mem_wr),    1);
        end
        tick();
        chk("stall_wait_req",  32'(mem_req), 0);
        chk("stall_wait_gd",   32'(grant_d), 1);
        n_mem_done = 1'b1; n_mem_rdata = 16'h0000;
        tick();
        chk("stall_d_done", 32'(d_done), 1);
        n_mem_done = 1'b0;
        tick();

        // I fill whose request drops while waiting still completes
        do_reset();
        n_i_req = 1'b1; n_i_addr = 16'h0300;
        tick();
        tick();
        chk("drop_mem_addr", 32'(mem_addr), 32'h0300);
        chk("drop_mem_wr",   32'(mem_wr),   0);
        n_i_req = 1'b0; n_i_addr = 16'h0000;
        tick();
        chk("drop_wait_busy", 32'(busy),   1);
        chk("drop_wait_done", 32'(i_done), 0);
        n_mem_done = 1'b1; n_mem_rdata = 16'hCAFE;
        tick();
        chk("drop_i_done",  32'(i_done),  1);
        chk("drop_i_rdata", 32'(i_rdata), 32'hCAFE);
        chk("drop_d_done",  32'(d_done),  0);
        n_mem_done = 1'b0;
        tick();

        // reset while in D_WAIT, then a stray completion
        do_reset();
        n_d_req = 1'b1; n_d_addr = 16'h0050;
        tick();
        n_d_req = 1'b0;
        tick();
        tick();
        chk("rstw_in_wait", 32'(grant_d), 1);
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0; n_mem_done = 1'b1; n_mem_rdata = 16'h7777;
        tick();
        chk("rstw_busy",    32'(busy),    0);
        chk("rstw_d_done",  32'(d_done),  0);
        chk("rstw_mem_req", 32'(mem_req), 0);
        n_mem_done = 1'b0;
        tick();
        chk("rstw_d_done2", 32'(d_done), 0);

        // randomized traffic with random stalls, latencies, stray completions and resets
        do_reset();
        rand_mem = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            n_rst       = ($urandom % 60 == 0);
            n_i_req     = ($urandom % 3 != 0);
            n_d_req     = (c % 1000 < 500) ? ($urandom % 3 != 0) : ($urandom % 4 == 0);
            n_d_wr      = $urandom % 2;
            n_i_addr    = AW'($urandom);
            n_d_addr    = AW'($urandom);
            n_d_wdata   = DW'($urandom);
            n_mem_stall = ($urandom % 3 == 0);
            tick();
        end
        rand_mem = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
